// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_arb_pkg
//  Purpose  : Shared types and constants for the APB master arbiter.
//             Covers the bus-phase state encoding, default widths and the
//             width of the wait-state counter.
//  Revision : 1.0  initial release
// ============================================================================
package apb_arb_pkg;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    // Counter width for the default timeout
    localparam int CNT_W = $clog2(DEF_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Wait counter width for an arbitrary timeout. When the timeout is
    // disabled (0) a 1-bit counter is kept so the vector is never zero-width.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Returns the first set
//             request at or above the pointer, wrapping modulo NUM_REQ, as
//             a one-hot vector and as a binary index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    localparam logic [IDX_W:0] c_NUM = NUM_REQ[IDX_W:0];

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [2*NUM_REQ-1:0] w_shift;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;
    logic [IDX_W:0]       w_idx;

    // Rotate so the pointer position becomes bit 0 of the search vector
    assign w_dbl   = {req_i, req_i};
    assign w_shift = w_dbl >> ptr_i;
    assign w_rot   = w_shift[NUM_REQ-1:0];
    assign any_o   = |req_i;

    // Lowest set bit of the rotated vector is the distance to the winner
    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    // Undo the rotation: winner = (pointer + distance) mod NUM_REQ
    assign w_sum       = {1'b0, ptr_i} + {1'b0, w_off};
    assign w_idx       = (w_sum >= c_NUM) ? (w_sum - c_NUM) : w_sum;
    assign grant_idx_o = w_idx[IDX_W-1:0];

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_onehot
            localparam logic [IDX_W-1:0] c_I = IDX_W'(i);
            assign grant_o[i] = any_o && (grant_idx_o == c_I);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_arbiter
//  Purpose  : Round-robin arbitration of NUM_REQ requesters onto a single
//             APB master port. Runs SETUP/ACCESS, tolerates PREADY wait
//             states with an optional timeout, and returns read data and
//             error status to the granted requester.
//  Revision : 1.0  initial release
// ============================================================================
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_W-1:0]       PADDR,
    output logic [DATA_W-1:0]       PWDATA,
    input  logic [DATA_W-1:0]       PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int c_IDX_W   = $clog2(NUM_REQ);
    localparam int c_CNT_W   = cnt_width(TIMEOUT);
    localparam int c_TO_LAST_I = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_TO_LAST_I[c_CNT_W-1:0];
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);

    apb_state_e           state_q;
    logic [c_IDX_W-1:0]   ptr_q;
    logic [c_IDX_W-1:0]   ptr_d;
    logic [c_IDX_W-1:0]   gidx_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic                 psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [ADDR_W-1:0]    paddr_q;
    logic [DATA_W-1:0]    pwdata_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;
    logic                 rsp_err_q;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_IDX_W-1:0]   w_gidx;
    logic                 w_any;
    logic                 w_accept;
    logic                 w_timeout;
    logic                 w_done;
    logic [ADDR_W-1:0]    w_addr  [NUM_REQ];
    logic [DATA_W-1:0]    w_wdata [NUM_REQ];

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            assign w_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (w_grant),
        .grant_idx_o (w_gidx),
        .any_o       (w_any)
    );

    // Grant is offered only while idle; reset masks it so nothing is accepted
    assign req_ready = (state_q == IDLE && !PRESET) ? w_grant : '0;
    assign w_accept  = w_any && (state_q == IDLE) && !PRESET;
    assign ptr_d     = (w_gidx == c_LAST_IDX) ? '0 : w_gidx + 1'b1;

    // Timeout fires on the TIMEOUT-th consecutive PREADY-low ACCESS cycle
    assign w_timeout = (TIMEOUT != 0) && !PREADY && (cnt_q == c_TO_LAST);
    assign w_done    = PREADY || w_timeout;

    // Bus-phase sequencer with all bus and response outputs registered
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        pwrite_q <= req_write[w_gidx];
                        paddr_q  <= w_addr[w_gidx];
                        pwdata_q <= req_write[w_gidx] ? w_wdata[w_gidx] : '0;
                        psel_q   <= 1'b1;
                        gidx_q   <= w_gidx;
                        ptr_q    <= ptr_d;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (w_done) begin
                        psel_q              <= 1'b0;
                        penable_q           <= 1'b0;
                        rsp_valid_q[gidx_q] <= 1'b1;
                        rsp_rdata_q         <= (PREADY && !pwrite_q) ? PRDATA : '0;
                        rsp_err_q           <= PREADY ? PSLVERR : 1'b1;
                        cnt_q               <= '0;
                        state_q             <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_arbiter
//  Purpose  : Directed self-checking bench for apb_master_arbiter with a
//             response scoreboard and a simple wait-state APB slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_master_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW-1:0]     PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    apb_master_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave model: PREADY rises after slv_wait ACCESS cycles unless hung
    int          slv_wait = 0;
    logic        slv_hang = 1'b0;
    logic        slv_err  = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    int          acc_cnt  = 0;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
        else                 acc_cnt <= 0;
    end
    assign PREADY  = slv_hang ? 1'b0 : (acc_cnt >= slv_wait);
    assign PRDATA  = slv_rdata;
    assign PSLVERR = slv_err;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic mon_en  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic drive_req(input int idx, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd);
        req_write[idx]          = wr;
        req_addr[idx*AW +: AW]  = addr;
        req_wdata[idx*DW +: DW] = wd;
        req_valid[idx]          = 1'b1;
    endtask

    task automatic push(input int idx, input logic [31:0] rd, input logic err);
        exp_t e;
        e.idx   = idx;
        e.rdata = rd;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Response monitor: every completion pulse must match the oldest expectation
    always begin
        @(posedge PCLK);
        #2;
        if (mon_en && rsp_valid !== '0) begin
            exp_t e;
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_onehot", 64'(rsp_valid), 64'(oh(e.idx)));
                chk("rsp_rdata",  64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err",    64'(rsp_err),   64'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n;
    int pen;

    initial begin
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) tick();

        // Reset values
        chk("rst_psel",      64'(PSEL),      64'd0);
        chk("rst_penable",   64'(PENABLE),   64'd0);
        chk("rst_pwrite",    64'(PWRITE),    64'd0);
        chk("rst_paddr",     64'(PADDR),     64'd0);
        chk("rst_pwdata",    64'(PWDATA),    64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        PRESET = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single write from req0, zero wait states
        drive_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
        #1;
        chk("wr_ready", 64'(req_ready), 64'(oh(0)));
        push(0, 32'h0, 1'b0);
        tick();
        req_valid = '0;
        chk("wr_t1_psel",    64'(PSEL),    64'd1);
        chk("wr_t1_penable", 64'(PENABLE), 64'd0);
        chk("wr_t1_pwrite",  64'(PWRITE),  64'd1);
        chk("wr_t1_paddr",   64'(PADDR),   64'h10);
        chk("wr_t1_pwdata",  64'(PWDATA),  64'hA5A5_0001);
        tick();
        chk("wr_t2_psel",    64'(PSEL),    64'd1);
        chk("wr_t2_penable", 64'(PENABLE), 64'd1);
        chk("wr_t2_paddr",   64'(PADDR),   64'h10);
        tick();
        chk("wr_t3_psel",    64'(PSEL),      64'd0);
        chk("wr_t3_rsp",     64'(rsp_valid), 64'(oh(0)));
        chk("wr_t3_err",     64'(rsp_err),   64'd0);

        // Read from req1 with three wait states
        slv_wait  = 3;
        slv_rdata = 32'hDEAD_BEEF;
        drive_req(1, 1'b0, 32'h24, 32'h1234_5678);
        #1;
        chk("rd_ready", 64'(req_ready), 64'(oh(1)));
        push(1, 32'hDEAD_BEEF, 1'b0);
        tick();
        req_valid = '0;
        chk("rd_pwrite", 64'(PWRITE), 64'd0);
        chk("rd_pwdata", 64'(PWDATA), 64'd0);
        chk("rd_paddr",  64'(PADDR),  64'h24);
        n = 0; pen = 0;
        while (rsp_valid === '0 && n < 40) begin
            tick(); n++;
            if (PENABLE) pen++;
        end
        chk("rd_latency",     64'(n),         64'd5);
        chk("rd_access_cyc",  64'(pen),       64'd4);
        chk("rd_rdata",       64'(rsp_rdata), 64'hDEAD_BEEF);
        slv_wait = 0;

        // Both requesters continuously valid: grants alternate 0,1,0,1
        drive_req(0, 1'b1, 32'h100, 32'h0000_0A00);
        drive_req(1, 1'b1, 32'h200, 32'h0000_0B00);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("fair_grant",   64'(req_ready), 64'(oh(k % 2)));
            chk("fair_gap_low", 64'(PSEL),      64'd0);
            push(k % 2, 32'h0, 1'b0);
            tick();
            if (k == 3) req_valid = '0;
            chk("fair_psel_hi", 64'(PSEL),  64'd1);
            chk("fair_paddr",   64'(PADDR), (k % 2 == 0) ? 64'h100 : 64'h200);
            tick();
            tick();
            #1;
        end

        // Hung slave: timeout after the 16th ACCESS cycle
        slv_hang  = 1'b1;
        slv_rdata = 32'h1234_5678;
        drive_req(0, 1'b0, 32'h30, 32'h0);
        #1;
        chk("to_ready", 64'(req_ready), 64'(oh(0)));
        push(0, 32'h0, 1'b1);
        tick();
        req_valid = '0;
        n = 0; pen = 0;
        while (rsp_valid === '0 && n < 60) begin
            tick(); n++;
            if (PENABLE) pen++;
        end
        chk("to_latency",    64'(n),         64'd17);
        chk("to_access_cyc", 64'(pen),       64'd16);
        chk("to_psel_low",   64'(PSEL),      64'd0);
        chk("to_err",        64'(rsp_err),   64'd1);
        chk("to_rdata",      64'(rsp_rdata), 64'd0);
        slv_hang = 1'b0;

        // Read with slave error: data still returned
        slv_err   = 1'b1;
        slv_rdata = 32'hCAFE_F00D;
        drive_req(1, 1'b0, 32'h40, 32'h0);
        #1;
        chk("se_ready", 64'(req_ready), 64'(oh(1)));
        push(1, 32'hCAFE_F00D, 1'b1);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("se_rsp",   64'(rsp_valid), 64'(oh(1)));
        chk("se_err",   64'(rsp_err),   64'd1);
        chk("se_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
        slv_err = 1'b0;
        tick();
        chk("hold_pulse", 64'(rsp_valid), 64'd0);
        chk("hold_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
        chk("hold_err",   64'(rsp_err),   64'd1);

        // Reset during ACCESS: no response, pointer back to 0
        slv_hang = 1'b1;
        drive_req(0, 1'b1, 32'h50, 32'h5555_AAAA);
        #1;
        chk("ra_ready", 64'(req_ready), 64'(oh(0)));
        tick();
        req_valid = '0;
        tick();
        chk("ra_in_access", 64'(PENABLE), 64'd1);
        PRESET = 1'b1;
        tick();
        chk("ra_psel",    64'(PSEL),      64'd0);
        chk("ra_penable", 64'(PENABLE),   64'd0);
        chk("ra_rsp",     64'(rsp_valid), 64'd0);
        PRESET   = 1'b0;
        slv_hang = 1'b0;
        drive_req(0, 1'b1, 32'h60, 32'h0000_0060);
        drive_req(1, 1'b1, 32'h70, 32'h0000_0070);
        #1;
        chk("ra_ptr_zero", 64'(req_ready), 64'(oh(0)));
        push(0, 32'h0, 1'b0);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("ra_next_rsp", 64'(rsp_valid), 64'(oh(0)));
        tick();
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Sequences the shared APB bus (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA) on behalf of NUM_REQ internal requesters.
- Round-robin arbitration picks one requester. The block then runs the APB SETUP → ACCESS phases, handles PREADY wait states with a timeout, and returns read data and error status to the granted requester.
- Sits between the register-access initiators (RAL front-door sequencer path, debug port) and the APB slave register block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, PADDR and request address width.
- DATA_W, 32, PWDATA/PRDATA width.
- TIMEOUT, 16, max ACCESS cycles with PREADY low before forced termination; 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESET  in  1  reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  one-hot command accept.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same slicing.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and on timeout.
- rsp_err  out  1  PSLVERR captured, or timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Clocking/reset: one clock, PCLK. PRESET is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; wait counter 0; round-robin pointer 0.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready is combinational and one-hot, and is asserted only in IDLE.
  - The winner is the first set req_valid searching from pointer upward, wrapping modulo NUM_REQ.
  - On accept (valid & ready): register PWRITE, PADDR and PWDATA (PWDATA = 0 for reads); PSEL←1; store grant index; pointer←grant+1 mod NUM_REQ; go to SETUP.
  - A requester dropping req_valid before accept is legal and discards nothing.
- SETUP: exactly one cycle with PSEL=1, PENABLE=0. Then PENABLE←1 and go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PWRITE/PADDR/PWDATA remain stable from SETUP until PSEL falls.
  - PREADY=1 sampled: PSEL←0, PENABLE←0; rsp_valid[grant]←1; rsp_rdata←PRDATA on reads, 0 on writes; rsp_err←PSLVERR; counter←0; go to IDLE.
  - PREADY=0: counter increments. If TIMEOUT≠0 and this is the TIMEOUT-th consecutive low cycle, terminate as above with rsp_err=1 and rsp_rdata=0.
- Latency with zero wait states:
  - Accept in cycle T.
  - PSEL high in T+1 (SETUP).
  - PENABLE high in T+2 (ACCESS); PREADY sampled there.
  - rsp_valid in T+3.
  - Each PREADY-low cycle adds 1.
- Back-to-back: the IDLE cycle T+3 may accept the next request, so PSEL is low for at least one cycle between transfers.
- rsp_valid has no backpressure. rsp_rdata and rsp_err hold their value until the next completion.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
- PREADY and PSLVERR are ignored outside ACCESS.
- PRESET asserted mid-transfer: next edge forces the reset values. No rsp_valid is issued for the aborted transfer, and the pointer returns to 0.
- PADDR is not checked for alignment.

Decomposition:
- Shared package apb_arb_pkg holds:
  - state enum apb_state_e {IDLE, SETUP, ACCESS};
  - default width constants;
  - localparam CNT_W = $clog2(TIMEOUT+1).
- One sub-module, rr_arbiter: combinational one-hot grant from the req vector and pointer, parameterised by NUM_REQ.

Test Plan:
- Reset then single write (req0, addr 0x10, wdata 0xA5A5_0001), PREADY tied 1 → PSEL in T+1, PENABLE in T+2, PADDR=0x10, PWDATA=0xA5A5_0001, rsp_valid=01 in T+3, rsp_err=0.
- Read from req1 at 0x24, slave returns PRDATA=0xDEAD_BEEF after 3 PREADY-low cycles → ACCESS lasts 4 cycles, rsp_valid=10 in T+6, rsp_rdata=0xDEAD_BEEF.
- Both requesters valid continuously for 4 transfers → grant order 0,1,0,1; PSEL low exactly one cycle between transfers.
- PREADY held 0, TIMEOUT=16 → termination after 16th ACCESS cycle, rsp_err=1, rsp_rdata=0, PSEL low next cycle.
- Read with PSLVERR=1 alongside PREADY=1 → rsp_err=1, rsp_rdata=PRDATA.
- PRESET asserted during ACCESS → PSEL/PENABLE=0 next edge, no rsp_valid; next request is granted to req0 first.
